// File: rtl/ika2151_pkg.sv
// Shared types and constants for the IKA2151 host-side write scheduler.
// Pure declarations: no logic, no latency, no flow control.
package ika2151_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_WR  = 3'd1,
        GAP      = 3'd2,
        DATA_WR  = 3'd3,
        BUSY     = 3'd4,
        POLL_RD  = 3'd5,
        POLL_GAP = 3'd6
    } wrsched_state_t;

    localparam int STATUS_BUSY_BIT = 7;
    localparam int TICK_CNT_W      = 8;

endpackage

// File: rtl/ika2151_wrsched_if.sv
// Requester handshakes and IKA2151 CPU-bus pins seen by the write scheduler.
// master = requesters + chip side (bench), slave = scheduler.
interface ika2151_wrsched_if;

    logic       i_REQ0_VALID;
    logic       o_REQ0_READY;
    logic [7:0] i_REQ0_ADDR;
    logic [7:0] i_REQ0_DATA;
    logic       i_REQ1_VALID;
    logic       o_REQ1_READY;
    logic [7:0] i_REQ1_ADDR;
    logic [7:0] i_REQ1_DATA;
    logic       o_CS_n;
    logic       o_WR_n;
    logic       o_RD_n;
    logic       o_A0;
    logic [7:0] o_D;
    logic [7:0] i_D;
    logic       o_BUSY;
    logic       o_GRANT;

    modport master (
        output i_REQ0_VALID, i_REQ0_ADDR, i_REQ0_DATA,
        output i_REQ1_VALID, i_REQ1_ADDR, i_REQ1_DATA,
        output i_D,
        input  o_REQ0_READY, o_REQ1_READY,
        input  o_CS_n, o_WR_n, o_RD_n, o_A0, o_D, o_BUSY, o_GRANT
    );

    modport slave (
        input  i_REQ0_VALID, i_REQ0_ADDR, i_REQ0_DATA,
        input  i_REQ1_VALID, i_REQ1_ADDR, i_REQ1_DATA,
        input  i_D,
        output o_REQ0_READY, o_REQ1_READY,
        output o_CS_n, o_WR_n, o_RD_n, o_A0, o_D, o_BUSY, o_GRANT
    );

endinterface

// File: rtl/ika2151_wrsched_rr.sv
// Two-way round-robin arbiter: purely combinational, zero latency.
// Grants the requester other than last_grant on contention; no valid -> no ready.
module ika2151_wrsched_rr (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] ready,
    output logic       next_grant
);

    always_comb begin
        next_grant = last_grant;
        ready      = 2'b00;
        if (valid == 2'b11) begin
            next_grant = ~last_grant;
        end else if (valid[0]) begin
            next_grant = 1'b0;
        end else if (valid[1]) begin
            next_grant = 1'b1;
        end
        if (|valid) begin
            ready = next_grant ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ika2151_wrsched.sv
// IKA2151 write scheduler: accepts in IDLE with same-cycle READY, then paces addr/data strobes in phiM ticks.
// READY is low outside IDLE; option IKA2151_WRSCHED_STATUS_POLL_EN replaces the fixed busy wait with status polling.
module ika2151_wrsched
    import ika2151_pkg::*;
#(
    parameter int WR_TICKS   = 4,
    parameter int GAP_TICKS  = 2,
    parameter int BUSY_TICKS = 64
) (
    input  logic             i_EMUCLK,
    input  logic             i_IC_n,
    input  logic             i_phiM_PCEN_n,
    ika2151_wrsched_if.slave bus
);

    if (WR_TICKS < 1 || WR_TICKS > 255) begin : g_bad_wr_ticks
        $error("WR_TICKS must be within 1..255");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_gap_ticks
        $error("GAP_TICKS must be within 1..255");
    end
    if (BUSY_TICKS < 1 || BUSY_TICKS > 255) begin : g_bad_busy_ticks
        $error("BUSY_TICKS must be within 1..255");
    end

    localparam logic [TICK_CNT_W-1:0] WR_LD   = TICK_CNT_W'(WR_TICKS);
    localparam logic [TICK_CNT_W-1:0] GAP_LD  = TICK_CNT_W'(GAP_TICKS);
    localparam logic [TICK_CNT_W-1:0] BUSY_LD = TICK_CNT_W'(BUSY_TICKS);

    wrsched_state_t          state_q, state_nxt;
    logic [TICK_CNT_W-1:0]   cnt_q, cnt_nxt;
    logic                    a0_q, a0_nxt;
    logic [7:0]              d_q, d_nxt;
    logic [7:0]              data_q, data_nxt;
    logic                    grant_q, grant_nxt;
    logic [1:0]              rr_ready;
    logic [1:0]              ready;
    logic                    rr_grant;
    logic                    tick;
    logic                    cnt_last;

`ifdef IKA2151_WRSCHED_STATUS_POLL_EN
    logic [8:0]              tmo_q, tmo_nxt;
`else
    logic                    unused_status;
    assign unused_status = ^bus.i_D;
`endif

    ika2151_wrsched_rr u_rr (
        .valid      ({bus.i_REQ1_VALID, bus.i_REQ0_VALID}),
        .last_grant (grant_q),
        .ready      (rr_ready),
        .next_grant (rr_grant)
    );

    assign tick     = ~i_phiM_PCEN_n;
    assign cnt_last = (cnt_q == TICK_CNT_W'(1));
    assign ready    = (state_q == IDLE) ? rr_ready : 2'b00;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a0_q    <= 1'b0;
            d_q     <= 8'h00;
            data_q  <= 8'h00;
            grant_q <= 1'b1;
`ifdef IKA2151_WRSCHED_STATUS_POLL_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            a0_q    <= a0_nxt;
            d_q     <= d_nxt;
            data_q  <= data_nxt;
            grant_q <= grant_nxt;
`ifdef IKA2151_WRSCHED_STATUS_POLL_EN
            tmo_q   <= tmo_nxt;
`endif
        end
    end

    // Every pacing state decrements on a tick; the tick that would reach zero
    // reloads for the following state instead, so each state lasts exactly N ticks.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        a0_nxt    = a0_q;
        d_nxt     = d_q;
        data_nxt  = data_q;
        grant_nxt = grant_q;
`ifdef IKA2151_WRSCHED_STATUS_POLL_EN
        tmo_nxt   = tmo_q;
`endif
        if (state_q != IDLE && tick) begin
            cnt_nxt = cnt_q - TICK_CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (|ready) begin
                    grant_nxt = rr_grant;
                    cnt_nxt   = WR_LD;
                    a0_nxt    = 1'b0;
                    d_nxt     = rr_grant ? bus.i_REQ1_ADDR : bus.i_REQ0_ADDR;
                    data_nxt  = rr_grant ? bus.i_REQ1_DATA : bus.i_REQ0_DATA;
                    state_nxt = ADDR_WR;
                end
            end
            ADDR_WR: begin
                if (tick && cnt_last) begin
                    cnt_nxt   = GAP_LD;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (tick && cnt_last) begin
                    cnt_nxt   = WR_LD;
                    a0_nxt    = 1'b1;
                    d_nxt     = data_q;
                    state_nxt = DATA_WR;
                end
            end
            DATA_WR: begin
                if (tick && cnt_last) begin
`ifdef IKA2151_WRSCHED_STATUS_POLL_EN
                    cnt_nxt   = WR_LD;
                    tmo_nxt   = 9'(2 * BUSY_TICKS);
                    a0_nxt    = 1'b0;
                    state_nxt = POLL_RD;
`else
                    cnt_nxt   = BUSY_LD;
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (tick && cnt_last) begin
                    state_nxt = IDLE;
                end
            end
`ifdef IKA2151_WRSCHED_STATUS_POLL_EN
            POLL_RD, POLL_GAP: begin
                if (tick) begin
                    tmo_nxt = tmo_q - 9'd1;
                    if (tmo_q == 9'd1) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (cnt_last && state_q == POLL_GAP) begin
                        cnt_nxt   = WR_LD;
                        state_nxt = POLL_RD;
                    end else if (cnt_last) begin
                        // Status is sampled on the last tick of the read strobe.
                        if (bus.i_D[STATUS_BUSY_BIT]) begin
                            cnt_nxt   = GAP_LD;
                            state_nxt = POLL_GAP;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
`endif
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.o_REQ0_READY = ready[0];
    assign bus.o_REQ1_READY = ready[1];
    assign bus.o_WR_n       = ~(state_q == ADDR_WR || state_q == DATA_WR);
`ifdef IKA2151_WRSCHED_STATUS_POLL_EN
    assign bus.o_CS_n       = ~(state_q == ADDR_WR || state_q == DATA_WR || state_q == POLL_RD);
    assign bus.o_RD_n       = ~(state_q == POLL_RD);
`else
    assign bus.o_CS_n       = ~(state_q == ADDR_WR || state_q == DATA_WR);
    assign bus.o_RD_n       = 1'b1;
`endif
    assign bus.o_A0         = a0_q;
    assign bus.o_D          = d_q;
    assign bus.o_BUSY       = (state_q != IDLE);
    assign bus.o_GRANT      = grant_q;

endmodule

// File: tb/tb_ika2151_wrsched.sv
// Bench for ika2151_wrsched: directed scenarios plus random traffic, checked each cycle against a
// tick-budget reference model of the address/gap/data/busy sequence.
module tb_ika2151_wrsched;

    localparam int W     = 4;
    localparam int G     = 2;
    localparam int B     = 64;
    localparam int TOTAL = 2 * W + G + B;

    logic clk;
    logic ic_n;
    logic pcen_n;
    int   n_checks;
    int   n_err;

    ika2151_wrsched_if bus ();

    ika2151_wrsched #(
        .WR_TICKS   (W),
        .GAP_TICKS  (G),
        .BUSY_TICKS (B)
    ) dut (
        .i_EMUCLK      (clk),
        .i_IC_n        (ic_n),
        .i_phiM_PCEN_n (pcen_n),
        .bus           (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a transfer is a budget of TOTAL ticks counted from acceptance.
    bit         m_active;
    int         m_ticks;
    logic       m_last;
    logic [7:0] m_addr, m_data;
    logic       m_idle_a0;
    logic [7:0] m_idle_d;
    int         dut_acc[$];
    logic       tog;

    function automatic int phase_of();
        if (!m_active)         return 0;
        if (m_ticks < W)       return 1;
        if (m_ticks < W + G)   return 2;
        if (m_ticks < 2*W + G) return 3;
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_ticks   = 0;
        m_last    = 1'b1;
        m_idle_a0 = 1'b0;
        m_idle_d  = 8'h00;
    endtask

    task automatic step(input logic pc, input logic v0, input logic v1,
                        input logic [7:0] ad0, input logic [7:0] dt0,
                        input logic [7:0] ad1, input logic [7:0] dt1);
        int         ph;
        logic       g;
        logic [1:0] exp_rdy;
        @(negedge clk);
        pcen_n           = pc;
        bus.i_REQ0_VALID = v0;
        bus.i_REQ0_ADDR  = ad0;
        bus.i_REQ0_DATA  = dt0;
        bus.i_REQ1_VALID = v1;
        bus.i_REQ1_ADDR  = ad1;
        bus.i_REQ1_DATA  = dt1;
        bus.i_D          = 8'($urandom);
        #1;
        ph = phase_of();
        g  = (v0 && v1) ? ~m_last : (v0 ? 1'b0 : 1'b1);
        exp_rdy = (ph == 0 && (v0 || v1)) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("ready", {bus.o_REQ1_READY, bus.o_REQ0_READY}, exp_rdy);
        chk("strobes", {bus.o_CS_n, bus.o_WR_n, bus.o_RD_n},
            (ph == 1 || ph == 3) ? 3'b001 : 3'b111);
        chk("a0", bus.o_A0, (ph == 0) ? m_idle_a0 : (ph >= 3));
        chk("d", bus.o_D, (ph == 0) ? m_idle_d : ((ph >= 3) ? m_data : m_addr));
        chk("busy", bus.o_BUSY, (ph != 0));
        chk("grant", bus.o_GRANT, m_last);
        if (bus.o_REQ0_READY)      dut_acc.push_back(0);
        else if (bus.o_REQ1_READY) dut_acc.push_back(1);
        @(posedge clk);
        if (ph == 0 && (v0 || v1)) begin
            m_active = 1;
            m_ticks  = 0;
            m_last   = g;
            m_addr   = g ? ad1 : ad0;
            m_data   = g ? dt1 : dt0;
        end else if (ph != 0 && !pc) begin
            m_ticks++;
            if (m_ticks == TOTAL) begin
                m_active  = 0;
                m_idle_a0 = 1'b1;
                m_idle_d  = m_data;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_REQ0_VALID = 1'b0;
        bus.i_REQ1_VALID = 1'b0;
        ic_n = 1'b0;
        #1;
        chk("rst_strobes", {bus.o_CS_n, bus.o_WR_n, bus.o_RD_n}, 3'b111);
        chk("rst_a0", bus.o_A0, 1'b0);
        chk("rst_d", bus.o_D, 8'h00);
        chk("rst_busy", bus.o_BUSY, 1'b0);
        chk("rst_ready", {bus.o_REQ1_READY, bus.o_REQ0_READY}, 2'b00);
        chk("rst_grant", bus.o_GRANT, 1'b1);
        model_reset();
        #3;
        ic_n = 1'b1;
    endtask

    task automatic run_idle(input int budget);
        for (int i = 0; i < budget && m_active; i++) begin
            step(tog, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
            tog = ~tog;
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        ic_n     = 1'b0;
        pcen_n   = 1'b1;
        tog      = 1'b1;
        bus.i_REQ0_VALID = 1'b0;
        bus.i_REQ0_ADDR  = 8'h00;
        bus.i_REQ0_DATA  = 8'h00;
        bus.i_REQ1_VALID = 1'b0;
        bus.i_REQ1_ADDR  = 8'h00;
        bus.i_REQ1_DATA  = 8'h00;
        bus.i_D          = 8'h00;
        model_reset();
        do_reset();

        // Single write from requester 0 with a tick every second cycle.
        step(tog, 1'b1, 1'b0, 8'h28, 8'h4A, 8'h00, 8'h00);
        tog = ~tog;
        run_idle(400);

        // Continuous contention from reset: grants must alternate starting with requester 0.
        do_reset();
        dut_acc.delete();
        for (int i = 0; i < 3000 && dut_acc.size() < 8; i++) begin
            step(tog, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tog = ~tog;
        end
        chk("order_count", 16'(dut_acc.size()), 16'd8);
        for (int k = 0; k < dut_acc.size() && k < 8; k++) begin
            chk("order", 16'(dut_acc[k]), 16'(k % 2));
        end
        run_idle(400);

        // Enable held high mid-gap: everything must freeze for 50 cycles.
        step(tog, 1'b1, 1'b0, 8'h31, 8'hC5, 8'h00, 8'h00);
        for (int i = 0; i < 100 && phase_of() != 2; i++) begin
            step(tog, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
            tog = ~tog;
        end
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom));
        end
        run_idle(400);

        // Reset mid data strobe, then a fresh request must restart from the address strobe.
        step(tog, 1'b0, 1'b1, 8'h00, 8'h00, 8'hB4, 8'hC0);
        for (int i = 0; i < 100 && phase_of() != 3; i++) begin
            step(tog, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
            tog = ~tog;
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        do_reset();
        step(tog, 1'b1, 1'b0, 8'h20, 8'h07, 8'h00, 8'h00);
        tog = ~tog;
        run_idle(400);

        // Random traffic: random enable, random contention, data sampled only at acceptance.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        run_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
